// File: rtl/seq_det_pkg.sv
// Shared definitions for the serializer and the 3-bit sequence detector bench.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: FSM state encodings, default word width and idle fill level, gap counter width.
package seq_det_pkg;

  typedef logic [1:0] ser_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam int   DEF_DATA_W   = 8;
  localparam logic DEF_IDLE_BIT = 1'b0;

  // Wide enough for GAP_CYCLES up to 15.
  localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/seq_bit_serializer_if.sv
// Parallel word handshake into the serializer (valid/ready, transfer on valid&&ready).
// Latency: n/a (wires only).
// Backpressure: din_ready from the slave side holds the word on din until accepted.
// Signals: din (word), din_valid (master -> slave), din_ready (slave -> master).
interface seq_bit_serializer_if
  import seq_det_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;

  modport master (output din, output din_valid, input  din_ready);
  modport slave  (input  din, input  din_valid, output din_ready);
endinterface

// File: rtl/seq_bit_serializer_hold_buf.sv
// Single-entry pending word register sitting in front of the shift register.
// Latency: a pushed word is visible on pend_dat/pend_valid the cycle after the push edge.
// Backpressure: din_ready is simply !pend_valid, registered, never a function of push.
// Ports: clk/rst, push+push_dat (store), pop (release), pend_dat/pend_valid, din_ready.
module ser_hold_buf
  import seq_det_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic [DATA_W-1:0] pend_dat,
  output logic              pend_valid,
  output logic              din_ready
);
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              vld_q, vld_d;

  // push only happens while empty, so push and pop never collide on a full entry.
  always_comb begin
    dat_d = dat_q;
    vld_d = vld_q;
    if (pop) begin
      vld_d = 1'b0;
    end
    if (push) begin
      dat_d = push_dat;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_q <= '0;
      vld_q <= 1'b0;
    end else begin
      dat_q <= dat_d;
      vld_q <= vld_d;
    end
  end

  assign pend_dat   = dat_q;
  assign pend_valid = vld_q;
  assign din_ready  = !vld_q;
endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the 3-bit sequence detector, one bit per clk on bit_out.
// Latency: first bit of an accepted word is on bit_out right after the transfer edge.
// Backpressure: din_ready drops while the shift reg is busy and the pending entry is full.
// Ports: clk, rst (async, active high), din_if (slave: din/din_valid/din_ready),
//        bit_out, bit_valid (word bit vs idle fill), word_done (last bit), busy.
module seq_bit_serializer
  import seq_det_pkg::*;
#(
  parameter int   DATA_W     = DEF_DATA_W,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_BIT   = DEF_IDLE_BIT,
  parameter int   GAP_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst,
  seq_bit_serializer_if.slave din_if,
  output logic               bit_out,
  output logic               bit_valid,
  output logic               word_done,
  output logic               busy
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [GAP_CNT_W-1:0] LAST_GAP = GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GAP_CNT_W-1:0] gap_q, gap_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              bit_out_q, bit_out_d;
  logic              bit_valid_q, bit_valid_d;
  logic              word_done_q, word_done_d;

  logic [DATA_W-1:0] pend_dat;
  logic [DATA_W-1:0] load_dat;
  logic              pend_valid;
  logic              din_ready_w;
  logic              fire;
  logic              load_slot;
  logic              push;
  logic              pop;

  // The bit currently being sent always sits at the outgoing end of the shift reg.
  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_on(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  ser_hold_buf #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_dat   (din_if.din),
    .pop        (pop),
    .pend_dat   (pend_dat),
    .pend_valid (pend_valid),
    .din_ready  (din_ready_w)
  );

  assign din_if.din_ready = din_ready_w;
  assign fire             = din_if.din_valid && din_ready_w;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    shreg_d     = shreg_q;
    bit_out_d   = IDLE_BIT;
    bit_valid_d = 1'b0;
    word_done_d = 1'b0;
    load_slot   = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    // Pending word has priority: it was accepted earlier and must go out first.
    load_dat    = pend_valid ? pend_dat : din_if.din;

    case (state_q)
      ST_SHIFT: begin
        if (cnt_q != LAST_BIT) begin
          cnt_d       = cnt_q + CNT_W'(1);
          shreg_d     = shift_on(shreg_q);
          bit_out_d   = head_bit(shreg_d);
          bit_valid_d = 1'b1;
          word_done_d = (cnt_d == LAST_BIT);
        end else if (GAP_CYCLES > 0) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end else begin
          load_slot = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q != LAST_GAP) begin
          gap_d = gap_q + GAP_CNT_W'(1);
        end else begin
          load_slot = 1'b1;
        end
      end
      default: begin
        load_slot = 1'b1;
      end
    endcase

    // A load slot is an edge where the shift reg can take a new word. A fresh
    // transfer on that edge bypasses the pending entry; any other transfer parks there.
    if (load_slot) begin
      if (pend_valid || fire) begin
        state_d     = ST_SHIFT;
        cnt_d       = '0;
        shreg_d     = load_dat;
        bit_out_d   = head_bit(load_dat);
        bit_valid_d = 1'b1;
        pop         = pend_valid;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      push = fire;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      gap_q       <= '0;
      shreg_q     <= '0;
      bit_out_q   <= IDLE_BIT;
      bit_valid_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      shreg_q     <= shreg_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      word_done_q <= word_done_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign word_done = word_done_q;
  assign busy      = (state_q == ST_SHIFT) || pend_valid;
endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: two instances (MSB-first/no gap/idle 0, LSB-first/gap 2/idle 1).
// Latency: n/a.
// Backpressure: source driver holds or retracts words while din_ready is low.
module tb_seq_bit_serializer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_bit_serializer_if #(.DATA_W(8)) a_if ();
  seq_bit_serializer_if #(.DATA_W(8)) b_if ();

  logic a_bit, a_bv, a_wd, a_busy;
  logic b_bit, b_bv, b_wd, b_busy;

  seq_bit_serializer #(
    .DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP_CYCLES(0)
  ) u_a (
    .clk(clk), .rst(rst), .din_if(a_if),
    .bit_out(a_bit), .bit_valid(a_bv), .word_done(a_wd), .busy(a_busy)
  );

  seq_bit_serializer #(
    .DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1), .GAP_CYCLES(2)
  ) u_b (
    .clk(clk), .rst(rst), .din_if(b_if),
    .bit_out(b_bit), .bit_valid(b_bv), .word_done(b_wd), .busy(b_busy)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] a_src[$], a_acc[$], b_src[$], b_acc[$];
  // Trace entry: [0] bit_out [1] bit_valid [2] word_done [3] busy [4] din_ready [5] transfer next edge
  logic [5:0] a_tr[$], b_tr[$];
  logic a_fire_s = 1'b0;
  logic b_fire_s = 1'b0;
  int a_rate = 100, a_drop = 0, b_rate = 100, b_drop = 0;

  logic [7:0] det_m;
  int         det_hits;
  logic [2:0] win;
  bit         obs[$];
  int         prev_v, gap_len, n_wait;

  task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    n_chk++;
    if (obs_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs_v, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Outputs are sampled on the falling edge; the transfer flag refers to the coming rising edge.
  initial forever begin
    @(negedge clk);
    a_fire_s = a_if.din_valid && a_if.din_ready;
    b_fire_s = b_if.din_valid && b_if.din_ready;
    a_tr.push_back({a_fire_s, a_if.din_ready, a_busy, a_wd, a_bv, a_bit});
    b_tr.push_back({b_fire_s, b_if.din_ready, b_busy, b_wd, b_bv, b_bit});
  end

  // Source drivers: act just after the rising edge; din is garbage whenever valid is low.
  initial forever begin
    @(posedge clk);
    #1;
    if (a_fire_s) begin
      a_acc.push_back(a_if.din);
      a_if.din_valid = 1'b0;
      a_if.din       = 8'($urandom);
    end else if (a_if.din_valid && $urandom_range(0, 99) < a_drop) begin
      a_src.push_front(a_if.din);
      a_if.din_valid = 1'b0;
      a_if.din       = 8'($urandom);
      continue;
    end
    if (!a_if.din_valid && a_src.size() > 0 && $urandom_range(0, 99) < a_rate) begin
      a_if.din       = a_src.pop_front();
      a_if.din_valid = 1'b1;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (b_fire_s) begin
      b_acc.push_back(b_if.din);
      b_if.din_valid = 1'b0;
      b_if.din       = 8'($urandom);
    end else if (b_if.din_valid && $urandom_range(0, 99) < b_drop) begin
      b_src.push_front(b_if.din);
      b_if.din_valid = 1'b0;
      b_if.din       = 8'($urandom);
      continue;
    end
    if (!b_if.din_valid && b_src.size() > 0 && $urandom_range(0, 99) < b_rate) begin
      b_if.din       = b_src.pop_front();
      b_if.din_valid = 1'b1;
    end
  end

  function automatic int nth_idx(input logic [5:0] tr[$], input int pos, input int nth);
    int c = 0;
    foreach (tr[t]) begin
      if (tr[t][pos]) begin
        c++;
        if (c == nth) return t;
      end
    end
    return -1000;
  endfunction

  function automatic int count_low(input logic [5:0] tr[$], input int pos);
    int c = 0;
    foreach (tr[t]) if (!tr[t][pos]) c++;
    return c;
  endfunction

  // Reference: each accepted word expands into 8 bits in the configured order;
  // the 8th bit of each word carries word_done; idle cycles carry the idle level.
  task automatic check_stream(input string tag, input logic [5:0] tr[$], input logic [7:0] words[$],
                              input bit msb, input logic idle);
    bit exp_q[$];
    int nv = 0;
    foreach (words[w]) begin
      for (int i = 0; i < 8; i++) exp_q.push_back(msb ? words[w][7-i] : words[w][i]);
    end
    foreach (tr[t]) begin
      if (tr[t][1]) begin
        if (nv < exp_q.size())
          chk({tag, "_bit"}, 32'({tr[t][0], tr[t][2], tr[t][3]}), 32'({exp_q[nv], (nv % 8) == 7, 1'b1}));
        nv++;
      end else begin
        chk({tag, "_idle"}, 32'({tr[t][0], tr[t][2]}), 32'({idle, 1'b0}));
      end
    end
    chk({tag, "_nbits"}, 32'(nv), 32'(exp_q.size()));
  endtask

  task automatic wait_idle(input bit sel_b);
    int n = 0;
    while (n < 3000) begin
      tick();
      if (sel_b ? (b_src.size() == 0 && !b_if.din_valid && !b_busy && !b_bv)
                : (a_src.size() == 0 && !a_if.din_valid && !a_busy && !a_bv)) break;
      n++;
    end
    if (n >= 3000) chk(sel_b ? "b_timeout" : "a_timeout", 32'(n), 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    a_if.din = '0; a_if.din_valid = 1'b0;
    b_if.din = '0; b_if.din_valid = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_a_bit",  32'(a_bit),  32'd0);
    chk("rst_a_bv",   32'(a_bv),   32'd0);
    chk("rst_a_wd",   32'(a_wd),   32'd0);
    chk("rst_a_busy", 32'(a_busy), 32'd0);
    chk("rst_a_rdy",  32'(a_if.din_ready), 32'd1);
    chk("rst_b_bit",  32'(b_bit),  32'd1);
    chk("rst_b_rdy",  32'(b_if.din_ready), 32'd1);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Single word, MSB first.
    a_tr.delete(); a_acc.delete();
    a_src.push_back(8'hA5);
    wait_idle(1'b0);
    check_stream("a5", a_tr, a_acc, 1'b1, 1'b0);
    chk("a5_latency", 32'(nth_idx(a_tr, 1, 1) - nth_idx(a_tr, 5, 1)), 32'd1);
    chk("a5_rdy_low", 32'(count_low(a_tr, 4)), 32'd0);

    // Back-to-back with valid held: no bubble, pending full for 7 cycles.
    a_tr.delete(); a_acc.delete();
    a_src.push_back(8'hFF); a_src.push_back(8'h00);
    wait_idle(1'b0);
    check_stream("ff00", a_tr, a_acc, 1'b1, 1'b0);
    chk("ff00_gap", 32'(nth_idx(a_tr, 1, 9) - nth_idx(a_tr, 1, 1) - 8), 32'd0);
    chk("ff00_rdy_low", 32'(count_low(a_tr, 4)), 32'd7);

    // Serial stream through a detector for 101/110/111.
    a_tr.delete(); a_acc.delete();
    a_src.push_back(8'b1011_0111);
    wait_idle(1'b0);
    check_stream("det", a_tr, a_acc, 1'b1, 1'b0);
    obs.delete();
    foreach (a_tr[t]) if (a_tr[t][1]) obs.push_back(a_tr[t][0]);
    det_m = '0; det_hits = 0;
    for (int i = 2; i < obs.size() && i < 8; i++) begin
      win = {obs[i-2], obs[i-1], obs[i]};
      if (win == 3'b101 || win == 3'b110 || win == 3'b111) begin
        det_m[i] = 1'b1;
        det_hits++;
      end
    end
    chk("det_mask", 32'(det_m), 32'h0000_00B4);
    chk("det_hits", 32'(det_hits), 32'd4);

    // LSB first with two forced idle cycles between words.
    b_tr.delete(); b_acc.delete();
    b_src.push_back(8'h01); b_src.push_back(8'h96);
    wait_idle(1'b1);
    check_stream("b_lsb", b_tr, b_acc, 1'b0, 1'b1);
    chk("b_gap", 32'(nth_idx(b_tr, 1, 9) - nth_idx(b_tr, 1, 1) - 8), 32'd2);

    // Random words with stalls and retracted valids.
    a_tr.delete(); a_acc.delete();
    a_rate = 60; a_drop = 30;
    for (int i = 0; i < 20; i++) a_src.push_back(8'($urandom));
    wait_idle(1'b0);
    check_stream("a_rand", a_tr, a_acc, 1'b1, 1'b0);
    chk("a_rand_words", 32'(a_acc.size()), 32'd20);

    b_tr.delete(); b_acc.delete();
    b_rate = 70; b_drop = 25;
    for (int i = 0; i < 12; i++) b_src.push_back(8'($urandom));
    wait_idle(1'b1);
    check_stream("b_rand", b_tr, b_acc, 1'b0, 1'b1);
    chk("b_rand_words", 32'(b_acc.size()), 32'd12);
    prev_v = -1;
    foreach (b_tr[t]) begin
      if (b_tr[t][1]) begin
        gap_len = t - prev_v - 1;
        if (prev_v >= 0 && gap_len > 0) chk("b_rand_gap_ge2", 32'(gap_len >= 2), 32'd1);
        prev_v = t;
      end
    end

    // Reset in the middle of a word with the pending entry full.
    a_rate = 100; a_drop = 0;
    a_tr.delete(); a_acc.delete();
    a_src.push_back(8'hA5); a_src.push_back(8'h3C);
    n_wait = 0;
    while ((a_tr.size() - count_low(a_tr, 1)) < 4 && n_wait < 100) begin
      tick();
      n_wait++;
    end
    chk("pre_rst_rdy",  32'(a_if.din_ready), 32'd0);
    chk("pre_rst_busy", 32'(a_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_bit",  32'(a_bit),  32'd0);
    chk("mid_rst_bv",   32'(a_bv),   32'd0);
    chk("mid_rst_wd",   32'(a_wd),   32'd0);
    chk("mid_rst_busy", 32'(a_busy), 32'd0);
    chk("mid_rst_rdy",  32'(a_if.din_ready), 32'd1);
    tick(); tick();
    rst = 1'b0;
    tick();
    a_tr.delete(); a_acc.delete();
    a_src.push_back(8'h5A);
    wait_idle(1'b0);
    check_stream("post_rst", a_tr, a_acc, 1'b1, 1'b0);
    chk("post_rst_latency", 32'(nth_idx(a_tr, 1, 1) - nth_idx(a_tr, 5, 1)), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
